// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Purpose : CPU-wide scalar types shared across the datapath.
// Contents: WORD_W and word_t, the machine word used for counters and data.
// ---------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage : cpu_types_pkg

// File: rtl/dp_types_pkg.sv
// ---------------------------------------------------------------------------
// dp_types_pkg
// Purpose : Datapath-local types.
// Contents: ru_state_t, the request unit sequencing state.
// ---------------------------------------------------------------------------
package dp_types_pkg;

    // FETCH : instruction fetch outstanding, waiting for ihit
    // DATA  : data access outstanding, waiting for dhit
    // HALT  : absorbing stop state, left only through reset
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DATA  = 2'd1,
        HALT  = 2'd2
    } ru_state_t;

endpackage : dp_types_pkg

// File: rtl/request_unit.sv
// ---------------------------------------------------------------------------
// request_unit
// Purpose : Sequences instruction and data memory requests for a multi-cycle
//           CPU and generates the one-cycle commit strobe (pc_en).
//
// Ports
//   CLK        in   system clock, rising edge
//   nRST       in   asynchronous active-low reset
//   ihit       in   instruction word valid this cycle
//   dhit       in   pending data access completed this cycle
//   dREN/dWEN  in   decode of current instruction: data read / data write
//   halt       in   decode of current instruction: HALT
//   imemREN    out  instruction fetch request (FETCH state only)
//   dmemREN    out  registered data read request
//   dmemWEN    out  registered data write request
//   pc_en      out  commit pulse: advance PC, write register file
//   halted     out  sticky halt indication
//   stall_cnt  out  cycles spent waiting on dhit (REQUEST_UNIT_PERF_EN only)
//
// Configuration
//   REQUEST_UNIT_PERF_EN : when defined, adds the stall_cnt port and a
//                          saturating data-wait counter.
// ---------------------------------------------------------------------------
module request_unit
    import cpu_types_pkg::*;
    import dp_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  logic  dhit,
    input  logic  dREN,
    input  logic  dWEN,
    input  logic  halt,
    output logic  imemREN,
    output logic  dmemREN,
    output logic  dmemWEN,
    output logic  pc_en,
    output logic  halted
`ifdef REQUEST_UNIT_PERF_EN
    ,
    output word_t stall_cnt
`endif
);

    ru_state_t state_reg;
    logic      dmem_ren_reg;
    logic      dmem_wen_reg;

    // Instruction-side decode qualifiers, only meaningful while fetching.
    logic fetch_hit;
    logic fetch_mem_op;

    assign fetch_hit    = (state_reg == FETCH) && ihit;
    assign fetch_mem_op = dREN || dWEN;

    // -----------------------------------------------------------------------
    // Sequencing FSM with registered data request bits
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg    <= FETCH;
            dmem_ren_reg <= 1'b0;
            dmem_wen_reg <= 1'b0;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (ihit) begin
                        // HALT outranks any memory op decoded alongside it,
                        // so a halting store never reaches memory.
                        if (halt) begin
                            state_reg <= HALT;
                        end else if (fetch_mem_op) begin
                            state_reg    <= DATA;
                            // A write wins if decode flags both directions.
                            dmem_ren_reg <= dREN && !dWEN;
                            dmem_wen_reg <= dWEN;
                        end
                    end
                end
                DATA: begin
                    // Request bits stay stable until memory acknowledges.
                    if (dhit) begin
                        state_reg    <= FETCH;
                        dmem_ren_reg <= 1'b0;
                        dmem_wen_reg <= 1'b0;
                    end
                end
                HALT: begin
                    state_reg    <= HALT;
                    dmem_ren_reg <= 1'b0;
                    dmem_wen_reg <= 1'b0;
                end
                default: begin
                    state_reg    <= FETCH;
                    dmem_ren_reg <= 1'b0;
                    dmem_wen_reg <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode
    // pc_en is combinational so that an ALU-only instruction commits in the
    // same cycle its word arrives, and a memory instruction commits in the
    // cycle dhit arrives. Each instruction yields exactly one pulse because
    // the two terms are mutually exclusive on state.
    // -----------------------------------------------------------------------
    assign imemREN = (state_reg == FETCH);
    assign dmemREN = dmem_ren_reg;
    assign dmemWEN = dmem_wen_reg;
    assign halted  = (state_reg == HALT);
    assign pc_en   = (fetch_hit && !halt && !fetch_mem_op)
                   || ((state_reg == DATA) && dhit);

`ifdef REQUEST_UNIT_PERF_EN
    // -----------------------------------------------------------------------
    // Data-wait counter: counts cycles in DATA without dhit, saturating.
    // It naturally holds in HALT since DATA is never re-entered.
    // -----------------------------------------------------------------------
    word_t stall_cnt_reg;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == DATA) && !dhit && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + word_t'(1);
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule : request_unit

// File: tb/tb_request_unit.sv
// ---------------------------------------------------------------------------
// tb_request_unit
// Directed vectors drive one instruction-level step per clock. Each step
// pushes its hand-computed expected outputs into a queue; an independent
// monitor pops and compares on the falling edge.
// Expected bit order: {imemREN, dmemREN, dmemWEN, pc_en, halted}
// Input bit order   : {ihit, dhit, dREN, dWEN, halt}
// ---------------------------------------------------------------------------
module tb_request_unit;

    logic        CLK;
    logic        nRST;
    logic        ihit, dhit, dREN, dWEN, halt;
    logic        imemREN, dmemREN, dmemWEN, pc_en, halted;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [4:0]  exp_bits;
        logic [31:0] exp_stall;
    } exp_t;

    exp_t sb_q[$];

    request_unit dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .ihit    (ihit),
        .dhit    (dhit),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .halt    (halt),
        .imemREN (imemREN),
        .dmemREN (dmemREN),
        .dmemWEN (dmemWEN),
        .pc_en   (pc_en),
        .halted  (halted)
`ifdef REQUEST_UNIT_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

`ifndef REQUEST_UNIT_PERF_EN
    assign stall_cnt = '0;
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [4:0] e, input logic [31:0] es);
        check({tag, ".imemREN"}, 32'(imemREN), 32'(e[4]));
        check({tag, ".dmemREN"}, 32'(dmemREN), 32'(e[3]));
        check({tag, ".dmemWEN"}, 32'(dmemWEN), 32'(e[2]));
        check({tag, ".pc_en"},   32'(pc_en),   32'(e[1]));
        check({tag, ".halted"},  32'(halted),  32'(e[0]));
`ifdef REQUEST_UNIT_PERF_EN
        check({tag, ".stall_cnt"}, stall_cnt, es);
`endif
    endtask

    // Monitor: compares whatever the stimulus queued for this cycle.
    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_outputs(e.tag, e.exp_bits, e.exp_stall);
            $display("txn %-12s imem=%0b dren=%0b dwen=%0b pc_en=%0b halted=%0b stall=%0d",
                     e.tag, imemREN, dmemREN, dmemWEN, pc_en, halted, stall_cnt);
        end
    end

    task automatic step(input string tag, input logic [4:0] in_bits,
                        input logic [4:0] exp_bits, input int exp_stall);
        exp_t e;
        @(posedge CLK);
        #1;
        {ihit, dhit, dREN, dWEN, halt} = in_bits;
        e.tag       = tag;
        e.exp_bits  = exp_bits;
        e.exp_stall = 32'(exp_stall);
        sb_q.push_back(e);
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        nRST = 1'b0;
        {ihit, dhit, dREN, dWEN, halt} = 5'b0;

        // Reset state
        step("reset",    5'b00000, 5'b10000, 0);
        @(negedge CLK); #1; nRST = 1'b1;

        // ALU-only instructions: commit every cycle
        for (int i = 0; i < 3; i++)
            step("alu", 5'b10000, 5'b10010, 0);

        // Load with two wait cycles
        step("ld_issue", 5'b10100, 5'b10000, 0);
        step("ld_wait0", 5'b00000, 5'b01000, 0);
        step("ld_wait1", 5'b00000, 5'b01000, 1);
        step("ld_hit",   5'b01000, 5'b01010, 2);
        step("ld_fetch", 5'b00000, 5'b10000, 2);

        // dhit in FETCH ignored
        step("dhit_fetch", 5'b01000, 5'b10000, 2);
        step("idle",       5'b00000, 5'b10000, 2);

        // Both dREN and dWEN: write wins; ihit in DATA ignored
        step("rw_issue", 5'b10110, 5'b10000, 2);
        step("rw_hit",   5'b11000, 5'b00110, 2);
        step("rw_fetch", 5'b00000, 5'b10000, 2);

        // Asynchronous reset mid-DATA
        step("rs_issue", 5'b10100, 5'b10000, 2);
        step("rs_wait",  5'b00000, 5'b01000, 2);
        @(negedge CLK); #2;
        nRST = 1'b0;
        #1;
        check_outputs("async_rst", 5'b10000, 32'd0);
        @(posedge CLK); #1; nRST = 1'b1;
        step("post_rst", 5'b00000, 5'b10000, 0);

        // HALT outranks a store; absorbing afterwards
        step("halt_dec", 5'b10011, 5'b10000, 0);
        for (int i = 0; i < 11; i++)
            step("halted", (i % 2 == 0) ? 5'b11110 : 5'b11101, 5'b00001, 0);

        @(negedge CLK); #1;
        check("queue_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_request_unit

// File: doc/request_unit.md
REQUEST_UNIT -- requirements
Module: request_unit

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 nRST  input  1  asynchronous active-low reset.
REQ-003 ihit  input  1  instruction memory returned valid word this cycle.
REQ-004 dhit  input  1  data memory completed the pending read/write this cycle.
REQ-005 dREN  input  1  control-unit decode: current instruction reads data memory.
REQ-006 dWEN  input  1  control-unit decode: current instruction writes data memory.
REQ-007 halt  input  1  control-unit decode: current instruction is HALT.
REQ-008 imemREN  output  1  instruction fetch request to memory.
REQ-009 dmemREN  output  1  registered data read request to memory.
REQ-010 dmemWEN  output  1  registered data write request to memory.
REQ-011 pc_en  output  1  one-cycle pulse: datapath commits instruction, advances PC, writes regfile.
REQ-012 halted  output  1  sticky halt indication to system.
REQ-013 stall_cnt  output  32  data-wait cycle count; present only with REQUEST_UNIT_PERF_EN.

Function
REQ-014 FSM states: FETCH, DATA, HALT; all state held in flops, outputs decoded from state plus registered request bits.
REQ-015 FETCH, ihit=0: remain FETCH, pc_en=0.
REQ-016 FETCH, ihit=1, halt=1: go HALT next cycle, pc_en=0; halt has priority over dREN/dWEN.
REQ-017 FETCH, ihit=1, halt=0, dREN=dWEN=0: remain FETCH, pc_en=1 same cycle (zero-latency commit).
REQ-018 FETCH, ihit=1, halt=0, dREN|dWEN: go DATA; dmemREN<=dREN&~dWEN, dmemWEN<=dWEN (write wins if both set); pc_en=0.
REQ-019 DATA, dhit=0: hold dmemREN/dmemWEN stable, pc_en=0, imemREN=0.
REQ-020 DATA, dhit=1: pc_en=1 same cycle; dmemREN/dmemWEN cleared next edge; return FETCH.
REQ-021 dhit in FETCH or HALT ignored; ihit in DATA or HALT ignored.
REQ-022 imemREN=1 in FETCH only; 0 in DATA and HALT.
REQ-023 HALT: absorbing until reset; imemREN=dmemREN=dmemWEN=pc_en=0, halted=1.
REQ-024 Minimum request latency: data request visible one cycle after the ihit that decodes it.
REQ-025 At most one pc_en pulse per instruction; never two consecutive pc_en without an intervening ihit.

Reset
REQ-026 nRST low asynchronously forces state=FETCH, dmemREN=0, dmemWEN=0, halted=0, stall_cnt=0.
REQ-027 Reset mid-DATA abandons pending request with no pc_en; first cycle after release is FETCH with imemREN=1.

Configuration
REQ-028 Macro REQUEST_UNIT_PERF_EN defined: stall_cnt port exists, increments by 1 every cycle in DATA with dhit=0, saturates at 32'hFFFFFFFF, holds in HALT.
REQ-029 Macro undefined: no stall_cnt port, no counter flops; all other behaviour identical.

Structure
REQ-030 State enum ru_state_t (FETCH, DATA, HALT) lives in dp_types_pkg; word_t width from cpu_types_pkg sizes stall_cnt.
REQ-031 Single flat module; no sub-module; counter inlined under the macro guard.

Verification
REQ-032 ihit=1, dREN=dWEN=halt=0 for 3 cycles -> pc_en=1 each cycle, dmemREN=dmemWEN=0, state FETCH.
REQ-033 ihit=1, dREN=1, then dhit=0 for 2 cycles, then dhit=1 -> dmemREN=1 for 3 cycles, pc_en=1 only on dhit cycle, imemREN=0 during wait; with PERF_EN stall_cnt=2.
REQ-034 ihit=1, dREN=1, dWEN=1 -> dmemWEN=1, dmemREN=0 next cycle.
REQ-035 ihit=1, halt=1, dWEN=1 -> HALT next cycle, halted=1, dmemWEN never asserted, all requests 0 for 10 further cycles regardless of ihit/dhit.
REQ-036 nRST pulsed low mid-DATA (dhit=0) -> outputs cleared immediately without clock, no pc_en, imemREN=1 after release.
REQ-037 dhit=1 asserted in FETCH with ihit=0 -> no pc_en, no state change.
